// File: rtl/enter_input_pkg.sv
// -----------------------------------------------------------------------------
// enter_input_pkg
// Shared types and defaults for the ENTER button / switch conditioning stage.
//   state_t           : debounce FSM states
//   DEBOUNCE_DEFAULT  : stable cycles required (20 ms at 50 MHz)
//   DATA_W_DEFAULT    : switch bus width
//   cnt_width()       : debounce counter width for a given cycle count
// -----------------------------------------------------------------------------
package enter_input_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEBOUNCE_DEFAULT = 1_000_000;
    localparam int DATA_W_DEFAULT   = 8;

    // $clog2 of the cycle count, never narrower than one bit so that the
    // counter vector stays legal for the smallest debounce settings.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : enter_input_pkg

// File: rtl/enter_input_conditioner_sync.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two flip-flop synchroniser for a bus of independent asynchronous bits.
// Each bit is synchronised on its own; no cross-bit coherency is implied.
// Ports:
//   clk    : destination clock
//   reset  : asynchronous active-high reset, loads RESET_VAL into both stages
//   d_i    : asynchronous input bits
//   q_o    : synchronised output bits (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    meta_q[gi] <= RESET_VAL[gi];
                    sync_q[gi] <= RESET_VAL[gi];
                end else begin
                    meta_q[gi] <= d_i[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/enter_input_conditioner.sv
// -----------------------------------------------------------------------------
// enter_input_conditioner
// Synchronises the raw active-low ENTER button and the switch bus, debounces
// the button into one enter_pulse per physical press, and captures the switch
// value into a valid/ack holding register at that press.
// Ports:
//   clk           : system clock
//   reset         : asynchronous active-high reset
//   nenter_raw    : raw ENTER button, active-low, bouncy, asynchronous
//   inputdata_raw : raw switch bus, asynchronous
//   data_ack      : consumer has taken data_out (clears data_valid)
//   enter_pulse   : one-cycle pulse per debounced press
//   data_out      : switch value captured at the accepted press
//   data_valid    : data_out holds unconsumed data
//   overrun       : sticky, a capture overwrote unacknowledged data
//   busy          : debounce FSM not idle
// -----------------------------------------------------------------------------
module enter_input_conditioner
    import enter_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int DATA_W          = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nenter_raw,
    input  logic [DATA_W-1:0] inputdata_raw,
    input  logic              data_ack,
    output logic              enter_pulse,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              overrun,
    output logic              busy
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronisers. The button resets to "released" so a reset never
    // looks like a press edge by itself.
    // ------------------------------------------------------------------
    logic              nenter_sync;
    logic [DATA_W-1:0] data_sync;
    logic              press;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync_nenter (
        .clk   (clk),
        .reset (reset),
        .d_i   (nenter_raw),
        .q_o   (nenter_sync)
    );

    sync_2ff #(
        .WIDTH     (DATA_W),
        .RESET_VAL ({DATA_W{1'b0}})
    ) u_sync_data (
        .clk   (clk),
        .reset (reset),
        .d_i   (inputdata_raw),
        .q_o   (data_sync)
    );

    assign press = ~nenter_sync;

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (press) begin
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!press) begin
                    // Too short to be a real press: drop it silently.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (!press) begin
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (press) begin
                    // Release bounce: still the same press, so no new pulse.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pulse and valid/ack holding register
    // ------------------------------------------------------------------
    logic              enter_pulse_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_pulse_q <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            enter_pulse_q <= accept;
            if (accept) begin
                data_q  <= data_sync;
                // A capture always leaves fresh data pending, even if the
                // consumer acknowledges the old value in the same cycle.
                valid_q <= 1'b1;
                // Only a genuine overwrite of unconsumed data is an overrun;
                // a simultaneous ack means the old value was taken.
                if (valid_q && !data_ack) begin
                    overrun_q <= 1'b1;
                end
            end else if (data_ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign enter_pulse = enter_pulse_q;
    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != IDLE);

endmodule : enter_input_conditioner

// File: tb/tb_enter_input_conditioner.sv
module tb_enter_input_conditioner;

    localparam int DEB = 4;
    localparam int DW  = 8;

    logic          clk;
    logic          reset;
    logic          nenter_raw;
    logic [DW-1:0] inputdata_raw;
    logic          data_ack;
    logic          enter_pulse;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          overrun;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    // Expected captured value for every press that should be accepted.
    logic [DW-1:0] sb_q[$];

    enter_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .DATA_W          (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .nenter_raw    (nenter_raw),
        .inputdata_raw (inputdata_raw),
        .data_ack      (data_ack),
        .enter_pulse   (enter_pulse),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .overrun       (overrun),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sb_q.delete();
    endtask

    // Scoreboard monitor: every pulse must match the oldest expected capture.
    always @(negedge clk) begin
        if (!reset && enter_pulse) begin
            pulse_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                check("sb_pulse_data", 32'(data_out), 32'(sb_q.pop_front()));
            end
        end
    end

    // One press: optional ack exactly in the accept cycle, then clean release.
    task automatic do_press(input logic [DW-1:0] d, input bit ack_at_accept);
        inputdata_raw = d;
        nenter_raw    = 1'b0;
        sb_q.push_back(d);
        for (int i = 0; i < 12; i++) begin
            tick();
            data_ack = (ack_at_accept && i == DEB + 1) ? 1'b1 : 1'b0;
        end
        data_ack   = 1'b0;
        nenter_raw = 1'b1;
        repeat (8) tick();
    endtask

    typedef struct {
        bit            rst_before;
        bit            press;
        logic [DW-1:0] data;
        bit            ack_at;
        bit            ack_after;
        logic [DW-1:0] exp_data;
        bit            exp_valid;
        bit            exp_ovr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p0;
        bit bounce_pat[20];

        vecs[0] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h02, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0};

        reset         = 1'b1;
        nenter_raw    = 1'b1;
        inputdata_raw = '0;
        data_ack      = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_pulse", 32'(enter_pulse), 32'd0);
        check("rst_data",  32'(data_out),    32'd0);
        check("rst_valid", 32'(data_valid),  32'd0);
        check("rst_ovr",   32'(overrun),     32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        reset = 1'b0;
        tick();

        // Clean press: pulse exactly after edge 2+DEB
        inputdata_raw = 8'hA5;
        nenter_raw    = 1'b0;
        sb_q.push_back(8'hA5);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("clean_pulse_e%0d", i), 32'(enter_pulse), 32'(i == DEB + 2));
            if (i == DEB + 1 || i == DEB + 2) begin
                check($sformatf("clean_valid_e%0d", i), 32'(data_valid), 32'(i == DEB + 2));
            end
        end
        check("clean_data", 32'(data_out), 32'hA5);
        nenter_raw = 1'b1;
        repeat (8) tick();
        check("clean_valid_held", 32'(data_valid), 32'd1);
        check("clean_ovr",        32'(overrun),    32'd0);
        check("clean_idle",       32'(busy),       32'd0);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        check("clean_ack_clears", 32'(data_valid), 32'd0);

        // Glitch: 2-cycle low is rejected
        p0 = pulse_cnt;
        nenter_raw = 1'b0;
        repeat (2) tick();
        nenter_raw = 1'b1;
        repeat (4) tick();
        check("glitch_busy",   32'(busy),              32'd0);
        check("glitch_valid",  32'(data_valid),        32'd0);
        repeat (4) tick();
        check("glitch_pulses", 32'(pulse_cnt - p0),    32'd0);

        // Bounce on press and release: exactly one pulse
        p0 = pulse_cnt;
        inputdata_raw = 8'h5A;
        sb_q.push_back(8'h5A);
        bounce_pat = '{0,1,0,1,0,1, 0,0,0,0,0,0,0,0,0,0, 1,0,1,0};
        for (int i = 0; i < 20; i++) begin
            nenter_raw = bounce_pat[i];
            tick();
        end
        nenter_raw = 1'b1;
        tick();
        nenter_raw = 1'b0;
        tick();
        nenter_raw = 1'b1;
        repeat (10) tick();
        check("bounce_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("bounce_idle",   32'(busy),           32'd0);
        check("bounce_data",   32'(data_out),       32'h5A);

        // Reset in PRESS_WAIT with cnt=2, button still held
        inputdata_raw = 8'h3C;
        nenter_raw    = 1'b0;
        repeat (5) tick();
        check("rmid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rmid_pulse", 32'(enter_pulse), 32'd0);
        check("rmid_data",  32'(data_out),    32'd0);
        check("rmid_valid", 32'(data_valid),  32'd0);
        check("rmid_ovr",   32'(overrun),     32'd0);
        check("rmid_busy",  32'(busy),        32'd0);
        sb_q.delete();
        tick();
        reset = 1'b0;
        sb_q.push_back(8'h3C);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("rmid_pulse_e%0d", i), 32'(enter_pulse), 32'(i == DEB + 2));
        end
        nenter_raw = 1'b1;
        repeat (8) tick();

        // Overrun / ack-collision vectors
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].rst_before) begin
                do_reset();
            end
            if (vecs[v].press) begin
                do_press(vecs[v].data, vecs[v].ack_at);
            end
            if (vecs[v].ack_after) begin
                data_ack = 1'b1;
                tick();
                data_ack = 1'b0;
                tick();
            end
            check($sformatf("vec%0d_data", v),  32'(data_out),   32'(vecs[v].exp_data));
            check($sformatf("vec%0d_valid", v), 32'(data_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_ovr", v),   32'(overrun),    32'(vecs[v].exp_ovr));
            check($sformatf("vec%0d_busy", v),  32'(busy),       32'd0);
        end

        check("sb_missing_pulses", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_enter_input_conditioner
